// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot / priority encoder pipeline.
// Holds the mode encodings and the saturating counter helper.
package onehot_pkg;

    localparam logic [1:0] MODE_STRICT = 2'd0;
    localparam logic [1:0] MODE_MSB    = 2'd1;
    localparam logic [1:0] MODE_LSB    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] maxv;
        if (w >= 32)
            maxv = '1;
        else
            maxv = (32'd1 << w) - 32'd1;
        if (v >= maxv)
            return maxv;
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/onehot_encode_core.sv
// Combinational encoder: strict one-hot, MSB or LSB priority.
// Ports: x (2**N bits), mode (2) in; y (N), err, zero out.
module onehot_encode_core #(
    parameter  int N = 3,
    localparam int W = 2 ** N
) (
    input  logic [W-1:0] x,
    input  logic [1:0]   mode,
    output logic [N-1:0] y,
    output logic         err,
    output logic         zero
);
    import onehot_pkg::*;

    logic [N-1:0] msb;
    logic [N-1:0] lsb;
    logic         onehot;

    // Ascending scan keeps the last hit (highest), descending the lowest.
    always_comb begin
        msb = '0;
        for (int i = 0; i < W; i++)
            if (x[i])
                msb = N'(i);
    end

    always_comb begin
        lsb = '0;
        for (int i = W - 1; i >= 0; i--)
            if (x[i])
                lsb = N'(i);
    end

    assign zero   = (x == '0);
    // A nonzero vector with no bit below its top bit is one-hot.
    assign onehot = !zero && ((x & (x - W'(1))) == '0);

    always_comb begin
        y   = msb;
        err = !onehot;
        unique case (mode)
            MODE_MSB: begin
                y   = msb;
                err = zero;
            end
            MODE_LSB: begin
                y   = lsb;
                err = zero;
            end
            default: begin
                y   = msb;
                err = !onehot;
            end
        endcase
    end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Two-stage pipelined one-hot/priority encoder with valid/ready
// handshakes and saturating error statistics.
// Ports: clk, rst; in_valid/in_ready/x/mode; out_valid/out_ready/
// y/err/zero; err_count, err_sticky, clr.
module onehot_encoder_pipe #(
    parameter  int N     = 3,
    parameter  int CNT_W = 8,
    localparam int W     = 2 ** N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     y,
    output logic             err,
    output logic             zero,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    input  logic             clr
);
    import onehot_pkg::*;

    logic             s1_valid;
    logic [W-1:0]     s1_x;
    logic [1:0]       s1_mode;

    logic             s2_load;
    logic             in_fire;
    logic             out_fire;

    logic [N-1:0]     c_y;
    logic             c_err;
    logic             c_zero;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 1: raw vector and mode.
    // A full stage 1 only accepts when stage 2 is loading,
    // so a new entry replaces one that is moving on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_mode  <= MODE_STRICT;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_x     <= x;
            s1_mode  <= mode;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    onehot_encode_core #(
        .N (N)
    ) u_core (
        .x    (s1_x),
        .mode (s1_mode),
        .y    (c_y),
        .err  (c_err),
        .zero (c_zero)
    );

    // Stage 2: encoded result, frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            err       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y    <= c_y;
                err  <= c_err;
                zero <= c_zero;
            end
        end
    end

    // Statistics: clear wins over a same-cycle error delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (out_fire && err) begin
            err_count  <= CNT_W'(sat_inc(32'(err_count),
                                         unsigned'(CNT_W)));
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: doc/onehot_encoder_pipe.md
# onehot_encoder_pipe

Pipelined, parametrised one-hot/priority encoder with a valid/ready handshake, per-result error flags and saturating error statistics. It generalises the combinational one-hot-to-binary encoder with error flag: a per-transaction mode selects strict one-hot checking, MSB-priority or LSB-priority encoding, and results are buffered through a two-stage pipeline with backpressure. It sits between request/interrupt-style bit vectors and binary-index consumers such as arbiters, mux selects and display drivers.

## Interface
- N, default 3: output index width; input vector width is 2**N (local constant W).
- CNT_W, default 8: width of the saturating error counter.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- x  in  W  bit vector to encode.
- mode  in  2  0 = strict one-hot, 1 = MSB priority, 2 = LSB priority, 3 = reserved (behaves as 0).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- y  out  N  encoded index.
- err  out  1  result error flag.
- zero  out  1  x was all-zero.
- err_count  out  CNT_W  number of erroneous results delivered, saturating.
- err_sticky  out  1  set by any erroneous delivered result; held until cleared.
- clr  in  1  synchronous clear of err_count and err_sticky.

## Operation
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Stage 1 registers x and mode. Stage 2 registers the encoded y, err and zero.
- Each stage holds its contents while its downstream is stalled. A stage loads when it is empty or its contents advance in the same cycle.
- in_ready = !s1_valid || s2 can load. s2 can load = !out_valid || out_ready.
- Encoding rules:
  - Mode 0/3: y = index of highest set bit. err = 1 unless exactly one bit is set; this includes x == 0.
  - Mode 1: y = index of highest set bit. err = zero.
  - Mode 2: y = index of lowest set bit. err = zero.
  - x == 0 in any mode: y = 0, zero = 1, err = 1.
- Statistics update only on an output handshake with err = 1:
  - err_count increments and saturates at 2**CNT_W-1 (no wrap).
  - err_sticky is set to 1.
- clr: err_count and err_sticky become 0 on the next edge. clr takes priority over an error handshake in the same cycle; that error is not counted. clr does not affect the pipeline.
- Reset values: out_valid = 0, y = 0, err = 0, zero = 0, err_count = 0, err_sticky = 0. Internal s1_valid = 0. in_ready is 1 on the first cycle after reset release.
- Reset mid-operation discards all in-flight data. No result is delivered for transactions accepted before reset.

## Timing
- Latency is 2 cycles from input handshake to out_valid when the pipeline is unstalled.
- Throughput is 1 transaction per cycle with out_ready held high.
- in_ready depends combinationally on out_ready; there is no combinational path from x to any output.
- y, err and zero are stable while out_valid && !out_ready.
- The pipeline holds 2 entries when stalled. A third input is refused (in_ready = 0) until out_ready rises. Simultaneous pop and push with both stages full is accepted in the same cycle without a bubble.
- err_count and err_sticky reflect a handshake on the cycle after it.

## Structure
- Package onehot_pkg contains:
  - the mode encodings (MODE_STRICT = 0, MODE_MSB = 1, MODE_LSB = 2, MODE_RSVD = 3);
  - a function returning the saturated increment of CNT_W-bit values.
- Sub-module onehot_encode_core: purely combinational, parametrised by N. Inputs x and mode; outputs y, err and zero. It is instantiated between stage 1 and stage 2.
- The top level contains the pipeline registers, handshake logic and statistics.

## Test plan
- N = 3, mode 0, x = 8'b0001_0000, out_ready = 1 -> 2 cycles later y = 4, err = 0, zero = 0; err_count stays 0.
- Mode 0, x = 8'b1000_0100 -> y = 7, err = 1; err_count = 1 and err_sticky = 1 the cycle after the handshake. Same x in mode 2 -> y = 2, err = 0.
- x = 0 in mode 1 -> y = 0, zero = 1, err = 1.
- Backpressure: out_ready = 0 while pushing 3 inputs back-to-back -> in_ready falls after 2 are accepted and y holds the first result. Raise out_ready -> results come out in order with no loss or duplication.
- CNT_W = 2, push 5 erroneous results -> err_count sticks at 3. Assert clr on the cycle of a 6th error handshake -> err_count = 0, err_sticky = 0.
- Assert rst while 2 entries are in flight -> out_valid = 0 immediately; no stale result appears after release; err_count = 0.
